// File: rtl/cpu_controller.sv
// Instruction register and Moore sequencer for the register-file/shifter/ALU datapath.
// Executes one decoded instruction per start pulse and reports idle via w.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_GET_A  = 3'd2,
        ST_GET_B  = 3'd3,
        ST_ALU    = 3'd4,
        ST_WR_REG = 3'd5,
        ST_WR_IMM = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] ir_r;

    logic [2:0]  opcode_s;
    logic [1:0]  op_s;
    logic [2:0]  rn_s;
    logic [2:0]  rd_s;
    logic [1:0]  sh_s;
    logic [2:0]  rm_s;

    assign opcode_s = ir_r[15:13];
    assign op_s     = ir_r[12:11];
    assign rn_s     = ir_r[10:8];
    assign rd_s     = ir_r[7:5];
    assign sh_s     = ir_r[4:3];
    assign rm_s     = ir_r[2:0];

    assign sximm8 = {{8{ir_r[7]}}, ir_r[7:0]};
    assign sximm5 = {{11{ir_r[4]}}, ir_r[4:0]};

    // State register and instruction register; IR only accepts a word while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_WAIT;
            ir_r    <= 16'h0000;
        end else begin
            state_r <= state_next_s;
            if (load && (state_r == ST_WAIT)) begin
                ir_r <= in;
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    // Next-state decode and Moore control strobes.
    always_comb begin
        state_next_s = state_r;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        loadc    = 1'b0;
        loads    = 1'b0;

        case (state_r)
            ST_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DECODE: begin
                case ({opcode_s, op_s})
                    5'b110_10:                     state_next_s = ST_WR_IMM;
                    5'b110_00, 5'b101_11:          state_next_s = ST_GET_B;
                    5'b101_00, 5'b101_01, 5'b101_10: state_next_s = ST_GET_A;
                    default:                       state_next_s = ST_WAIT;
                endcase
            end
            ST_GET_A: begin
                readnum      = rn_s;
                loada        = 1'b1;
                state_next_s = ST_GET_B;
            end
            ST_GET_B: begin
                readnum      = rm_s;
                loadb        = 1'b1;
                state_next_s = ST_ALU;
            end
            ST_ALU: begin
                shift = sh_s;
                // MOV and MVN pass B through the ALU with A forced to zero.
                case ({opcode_s, op_s})
                    5'b110_00: begin
                        ALUop = 2'b00; asel = 1'b1; loadc = 1'b1;
                        state_next_s = ST_WR_REG;
                    end
                    5'b101_00: begin
                        ALUop = 2'b00; loadc = 1'b1;
                        state_next_s = ST_WR_REG;
                    end
                    5'b101_01: begin
                        ALUop = 2'b01; loads = 1'b1;
                        state_next_s = ST_WAIT;
                    end
                    5'b101_10: begin
                        ALUop = 2'b10; loadc = 1'b1;
                        state_next_s = ST_WR_REG;
                    end
                    5'b101_11: begin
                        ALUop = 2'b11; asel = 1'b1; loadc = 1'b1;
                        state_next_s = ST_WR_REG;
                    end
                    default: begin
                        state_next_s = ST_WAIT;
                    end
                endcase
            end
            ST_WR_REG: begin
                writenum     = rd_s;
                vsel         = 2'b00;
                write        = 1'b1;
                state_next_s = ST_WAIT;
            end
            ST_WR_IMM: begin
                writenum     = rn_s;
                vsel         = 2'b10;
                write        = 1'b1;
                state_next_s = ST_WAIT;
            end
            default: begin
                state_next_s = ST_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed and randomized instructions
// compared cycle by cycle against a per-instruction expected control trace.
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic        load;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    cpu_controller dut (
        .clk(clk), .reset(reset), .load(load), .s(s), .in(in),
        .w(w), .readnum(readnum), .writenum(writenum), .write(write),
        .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       loadc;
        logic       loads;
    } ctl_t;

    int          tests_run;
    int          tests_failed;
    logic [15:0] cur_ir;
    ctl_t        exp_q[$];

    function automatic ctl_t observed();
        ctl_t c;
        c = {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
             shift, ALUop, loadc, loads};
        return c;
    endfunction

    function automatic ctl_t idle_ctl();
        ctl_t c;
        c = '0;
        c.w = 1'b1;
        return c;
    endfunction

    function automatic logic [31:0] sx_pair(input logic [15:0] v);
        int a;
        int b;
        logic [15:0] ea;
        logic [15:0] eb;
        a = int'(v[7:0]);
        if (a > 127) a = a - 256;
        b = int'(v[4:0]);
        if (b > 15) b = b - 32;
        ea = 16'(a);
        eb = 16'(b);
        return {ea, eb};
    endfunction

    // Expected non-idle cycles for one instruction, built from its mnemonic.
    function automatic void build_expect(input logic [15:0] ins);
        ctl_t c;
        logic is_movi, is_mov, is_add, is_cmp, is_and, is_mvn;
        is_movi = (ins[15:13] == 3'b110) && (ins[12:11] == 2'b10);
        is_mov  = (ins[15:13] == 3'b110) && (ins[12:11] == 2'b00);
        is_add  = (ins[15:13] == 3'b101) && (ins[12:11] == 2'b00);
        is_cmp  = (ins[15:13] == 3'b101) && (ins[12:11] == 2'b01);
        is_and  = (ins[15:13] == 3'b101) && (ins[12:11] == 2'b10);
        is_mvn  = (ins[15:13] == 3'b101) && (ins[12:11] == 2'b11);
        exp_q.delete();
        c = '0;
        exp_q.push_back(c);
        if (is_movi) begin
            c = '0; c.writenum = ins[10:8]; c.vsel = 2'b10; c.write = 1'b1;
            exp_q.push_back(c);
        end else if (is_mov || is_add || is_cmp || is_and || is_mvn) begin
            if (is_add || is_cmp || is_and) begin
                c = '0; c.readnum = ins[10:8]; c.loada = 1'b1;
                exp_q.push_back(c);
            end
            c = '0; c.readnum = ins[2:0]; c.loadb = 1'b1;
            exp_q.push_back(c);
            c = '0;
            c.shift = ins[4:3];
            c.aluop = is_cmp ? 2'b01 : is_and ? 2'b10 : is_mvn ? 2'b11 : 2'b00;
            c.asel  = is_mov || is_mvn;
            c.loads = is_cmp;
            c.loadc = !is_cmp;
            exp_q.push_back(c);
            if (!is_cmp) begin
                c = '0; c.writenum = ins[7:5]; c.vsel = 2'b00; c.write = 1'b1;
                exp_q.push_back(c);
            end
        end
    endfunction

    task automatic check_idle(input string name);
        tests_run++;
        if (observed() !== idle_ctl()) begin
            tests_failed++;
            $display("FAIL %s ctl: got %h expected %h", name, observed(), idle_ctl());
        end
        tests_run++;
        if ({sximm8, sximm5} !== sx_pair(cur_ir)) begin
            tests_failed++;
            $display("FAIL %s imm: got %h expected %h", name, {sximm8, sximm5}, sx_pair(cur_ir));
        end
    endtask

    task automatic check_steps(input string name, input int inj_step);
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (observed() !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s step%0d ctl: got %h expected %h", name, i, observed(), exp_q[i]);
            end
            tests_run++;
            if ({sximm8, sximm5} !== sx_pair(cur_ir)) begin
                tests_failed++;
                $display("FAIL %s step%0d imm: got %h expected %h", name, i,
                         {sximm8, sximm5}, sx_pair(cur_ir));
            end
            if (i == inj_step) begin
                load = 1'b1;
                in   = 16'h1234;
            end
            @(negedge clk);
            load = 1'b0;
        end
    endtask

    // Starts at a negedge in WAIT and ends at a negedge back in WAIT.
    task automatic run_instr(input string name, input logic [15:0] ins, input int inj_step);
        check_idle({name, "_pre"});
        load = 1'b1; s = 1'b1; in = ins;
        @(negedge clk);
        load = 1'b0; s = 1'b0;
        cur_ir = ins;
        build_expect(ins);
        check_steps(name, inj_step);
        check_idle({name, "_post"});
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        cur_ir = 16'h0000;
        check_idle("reset");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("idle_hold");
        end
    endtask

    task automatic test_load_only();
        logic [15:0] v;
        v = 16'($urandom());
        load = 1'b1; in = v;
        @(negedge clk);
        load = 1'b0;
        cur_ir = v;
        check_idle("load_only");
    endtask

    task automatic test_mov_imm();
        run_instr("movi_r0_7", 16'hD007, -1);
        run_instr("movi_r1_m2", 16'hD1FE, -1);
    endtask

    task automatic test_alu_ops();
        run_instr("add_r2", 16'hA148, -1);
        run_instr("cmp_r0", 16'hA800, -1);
        run_instr("mvn_r3", 16'hB860, -1);
    endtask

    task automatic test_undefined();
        run_instr("undef_e000", 16'hE000, -1);
        run_instr("undef_0000", 16'h0000, -1);
    endtask

    task automatic test_load_ignored();
        // ADD steps: DECODE, GET_A, GET_B, ALU (index 3) -- load presented leaving ALU.
        run_instr("add_load_in_alu", 16'hA148, 3);
        run_instr("mvn_load_in_getb", 16'hB860, 1);
    endtask

    task automatic test_reset_mid();
        check_idle("rst_mid_pre");
        load = 1'b1; s = 1'b1; in = 16'hA148;
        @(negedge clk);
        load = 1'b0; s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur_ir = 16'h0000;
        check_idle("rst_mid_after");
        @(negedge clk);
        check_idle("rst_mid_after2");
    endtask

    task automatic test_back_to_back();
        check_idle("b2b_pre");
        load = 1'b1; s = 1'b1; in = 16'hA148;
        @(negedge clk);
        load = 1'b0;
        cur_ir = 16'hA148;
        build_expect(16'hA148);
        for (int rep = 0; rep < 3; rep++) begin
            check_steps("b2b", -1);
            check_idle("b2b_gap");
            if (rep < 2) begin
                @(negedge clk);
            end else begin
                s = 1'b0;
            end
        end
        @(negedge clk);
        check_idle("b2b_end");
    endtask

    task automatic test_random();
        logic [15:0] ins;
        int pick;
        int inj;
        for (int n = 0; n < 40; n++) begin
            ins  = 16'($urandom());
            pick = int'($urandom_range(0, 6));
            case (pick)
                0: ins[15:11] = 5'b110_10;
                1: ins[15:11] = 5'b110_00;
                2: ins[15:11] = 5'b101_00;
                3: ins[15:11] = 5'b101_01;
                4: ins[15:11] = 5'b101_10;
                5: ins[15:11] = 5'b101_11;
                default: ;
            endcase
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr("random", ins, inj);
        end
    endtask

    initial begin
        clk = 1'b0;
        tests_run = 0;
        tests_failed = 0;
        cur_ir = 16'h0000;
        test_reset();
        test_load_only();
        test_mov_imm();
        test_alu_ops();
        test_undefined();
        test_load_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
